// File: rtl/shop_requester.sv
// shop_requester
// Requester side of the wallet purchase interface. A debounced buy press
// for an item that is not cooling down becomes one purchase request with a
// level-scaled, saturated cost. The request is held until the wallet
// acknowledges it or a timeout expires. A successful buy produces a spawn
// pulse and starts that item's cooldown, which counts down on game ticks.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   tick                game-tick enable (one clk cycle wide)
//   buy_pulse           single-cycle buy request
//   buy_item, level     item index and upgrade level, sampled with buy_pulse
//   purchase            request to wallet, held until ack or timeout
//   unit_cost           cost of the pending request
//   ack, ok             wallet response strobe and verdict
//   spawn, spawn_item   one-cycle pulse and item index of a successful buy
//   deny                one-cycle pulse: refused, cooling or timed out
//   timeout             one-cycle pulse, coincident with deny on timeout
//   busy                high while a transaction is outstanding
//   cooling             bit i high while item i is locked
module shop_requester #(
    parameter int NUM_ITEMS      = 4,
    parameter int COST_W         = 12,
    parameter int BASE0          = 10,
    parameter int BASE1          = 25,
    parameter int BASE2          = 60,
    parameter int BASE3          = 150,
    parameter int COOLDOWN_TICKS = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 buy_pulse,
    input  logic [1:0]           buy_item,
    input  logic [1:0]           level,
    output logic                 purchase,
    output logic [COST_W-1:0]    unit_cost,
    input  logic                 ack,
    input  logic                 ok,
    output logic                 spawn,
    output logic [1:0]           spawn_item,
    output logic                 deny,
    output logic                 timeout,
    output logic                 busy,
    output logic [NUM_ITEMS-1:0] cooling
);

    localparam int CD_W = $clog2(COOLDOWN_TICKS + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] COST_MAX = (32'd1 << COST_W) - 32'd1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [1:0]        item_q, item_d;
    logic [COST_W-1:0] cost_q, cost_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              spawn_q, spawn_d;
    logic              deny_q, deny_d;
    logic              timeout_q, timeout_d;
    logic [CD_W-1:0]   cd_cnt_q [NUM_ITEMS];
    logic [CD_W-1:0]   cd_cnt_d [NUM_ITEMS];
    logic [NUM_ITEMS-1:0] cd_load;

    logic [31:0]       base_sel;
    logic [31:0]       cost_shifted;
    logic [COST_W-1:0] cost_calc;

    // Level-scaled cost, computed wide so the shift cannot wrap before the
    // saturation compare.
    always_comb begin
        case (buy_item)
            2'd0:    base_sel = 32'(BASE0);
            2'd1:    base_sel = 32'(BASE1);
            2'd2:    base_sel = 32'(BASE2);
            default: base_sel = 32'(BASE3);
        endcase
        cost_shifted = base_sel << level;
        cost_calc    = (cost_shifted > COST_MAX) ? COST_MAX[COST_W-1:0]
                                                 : cost_shifted[COST_W-1:0];
    end

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            cooling[i] = (cd_cnt_q[i] != '0);
        end
    end

    // Transaction FSM. The timeout counter holds the number of completed
    // WAIT cycles, so expiry is checked on the last allowed cycle; an ack
    // in that same cycle is handled first.
    always_comb begin
        state_d   = state_q;
        item_d    = item_q;
        cost_d    = cost_q;
        to_cnt_d  = to_cnt_q;
        spawn_d   = 1'b0;
        deny_d    = 1'b0;
        timeout_d = 1'b0;
        cd_load   = '0;
        case (state_q)
            S_IDLE: begin
                if (buy_pulse) begin
                    if (cooling[buy_item]) begin
                        deny_d = 1'b1;
                    end else begin
                        item_d   = buy_item;
                        cost_d   = cost_calc;
                        to_cnt_d = '0;
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (ack) begin
                    state_d = S_IDLE;
                    if (ok) begin
                        spawn_d         = 1'b1;
                        cd_load[item_q] = 1'b1;
                    end else begin
                        deny_d = 1'b1;
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = S_IDLE;
                    deny_d    = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Per-item cooldowns: a load from a successful buy overrides a
    // coincident tick so the item always gets its full lock time.
    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (cd_load[i]) begin
                cd_cnt_d[i] = CD_W'(COOLDOWN_TICKS);
            end else if (tick && (cd_cnt_q[i] != '0)) begin
                cd_cnt_d[i] = cd_cnt_q[i] - 1'b1;
            end else begin
                cd_cnt_d[i] = cd_cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            item_q    <= '0;
            cost_q    <= '0;
            to_cnt_q  <= '0;
            spawn_q   <= 1'b0;
            deny_q    <= 1'b0;
            timeout_q <= 1'b0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                cd_cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            item_q    <= item_d;
            cost_q    <= cost_d;
            to_cnt_q  <= to_cnt_d;
            spawn_q   <= spawn_d;
            deny_q    <= deny_d;
            timeout_q <= timeout_d;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                cd_cnt_q[i] <= cd_cnt_d[i];
            end
        end
    end

    // The request is outstanding exactly while in WAIT, so the async reset
    // of state_q drops purchase immediately.
    assign purchase   = (state_q == S_WAIT);
    assign busy       = (state_q == S_WAIT);
    assign unit_cost  = cost_q;
    assign spawn      = spawn_q;
    assign spawn_item = item_q;
    assign deny       = deny_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_shop_requester.sv
// tb_shop_requester
// Directed bench for shop_requester. A second instance built with
// BASE3=1500 shares all inputs and is used for the cost saturation case.
module tb_shop_requester;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        buy_pulse;
    logic [1:0]  buy_item;
    logic [1:0]  level;
    logic        ack;
    logic        ok;

    logic        purchase;
    logic [11:0] unit_cost;
    logic        spawn;
    logic [1:0]  spawn_item;
    logic        deny;
    logic        timeout;
    logic        busy;
    logic [3:0]  cooling;

    logic        sat_purchase;
    logic [11:0] sat_unit_cost;
    logic        sat_spawn;
    logic [1:0]  sat_spawn_item;
    logic        sat_deny;
    logic        sat_timeout;
    logic        sat_busy;
    logic [3:0]  sat_cooling;

    int checks = 0;
    int errors = 0;

    shop_requester dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .buy_pulse  (buy_pulse),
        .buy_item   (buy_item),
        .level      (level),
        .purchase   (purchase),
        .unit_cost  (unit_cost),
        .ack        (ack),
        .ok         (ok),
        .spawn      (spawn),
        .spawn_item (spawn_item),
        .deny       (deny),
        .timeout    (timeout),
        .busy       (busy),
        .cooling    (cooling)
    );

    shop_requester #(.BASE3(1500)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .buy_pulse  (buy_pulse),
        .buy_item   (buy_item),
        .level      (level),
        .purchase   (sat_purchase),
        .unit_cost  (sat_unit_cost),
        .ack        (ack),
        .ok         (ok),
        .spawn      (sat_spawn),
        .spawn_item (sat_spawn_item),
        .deny       (sat_deny),
        .timeout    (sat_timeout),
        .busy       (sat_busy),
        .cooling    (sat_cooling)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic bp, input logic [1:0] item,
                                 input logic [1:0] lvl, input logic a,
                                 input logic o, input logic t);
        buy_pulse = bp;
        buy_item  = item;
        level     = lvl;
        ack       = a;
        ok        = o;
        tick      = t;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic tickOnce();
        applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
        stepClock();
        idleInputs();
        stepClock();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        checkOutput("rst_purchase", 32'(purchase), 32'd0);
        checkOutput("rst_unit_cost", 32'(unit_cost), 32'd0);
        checkOutput("rst_spawn", 32'(spawn), 32'd0);
        checkOutput("rst_spawn_item", 32'(spawn_item), 32'd0);
        checkOutput("rst_deny", 32'(deny), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_cooling", 32'(cooling), 32'd0);
        rst = 1'b0;
        stepClock();

        // Level-0 buy of item 1, acked with ok two cycles later
        applyStimulus(1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        stepClock();
        idleInputs();
        checkOutput("t1_purchase", 32'(purchase), 32'd1);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_cost", 32'(unit_cost), 32'd25);
        stepClock();
        checkOutput("t1_purchase_held", 32'(purchase), 32'd1);
        checkOutput("t1_cost_held", 32'(unit_cost), 32'd25);
        applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        stepClock();
        idleInputs();
        checkOutput("t1_spawn", 32'(spawn), 32'd1);
        checkOutput("t1_spawn_item", 32'(spawn_item), 32'd1);
        checkOutput("t1_deny", 32'(deny), 32'd0);
        checkOutput("t1_purchase_drop", 32'(purchase), 32'd0);
        checkOutput("t1_busy_drop", 32'(busy), 32'd0);
        checkOutput("t1_cooling", 32'(cooling), 32'b0010);
        stepClock();
        checkOutput("t1_spawn_pulse", 32'(spawn), 32'd0);
        for (int k = 0; k < 7; k++) begin
            tickOnce();
        end
        checkOutput("t1_cooling_7ticks", 32'(cooling), 32'b0010);

        // Rebuy of item 1 while it is cooling is refused
        applyStimulus(1'b1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
        stepClock();
        idleInputs();
        checkOutput("cd_deny", 32'(deny), 32'd1);
        checkOutput("cd_no_purchase", 32'(purchase), 32'd0);
        checkOutput("cd_no_timeout", 32'(timeout), 32'd0);
        stepClock();
        checkOutput("cd_deny_pulse", 32'(deny), 32'd0);
        tickOnce();
        checkOutput("t1_cooling_8ticks", 32'(cooling), 32'b0000);

        // Item 3 at level 2, plus the saturating build
        applyStimulus(1'b1, 2'd3, 2'd2, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("t2_cost", 32'(unit_cost), 32'd600);
        checkOutput("t2_cost_sat", 32'(sat_unit_cost), 32'd4095);
        checkOutput("t2_purchase", 32'(purchase), 32'd1);
        // Buy of item 0 while busy is dropped
        applyStimulus(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("busy_purchase", 32'(purchase), 32'd1);
        checkOutput("busy_cost", 32'(unit_cost), 32'd600);
        checkOutput("busy_no_deny", 32'(deny), 32'd0);
        // Ack with a coincident tick: cooldown loads to the full count
        applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1);
        stepClock();
        idleInputs();
        checkOutput("t2_spawn", 32'(spawn), 32'd1);
        checkOutput("t2_spawn_item", 32'(spawn_item), 32'd3);
        checkOutput("t2_cooling", 32'(cooling), 32'b1000);
        stepClock();
        checkOutput("busy_no_second_req", 32'(purchase), 32'd0);
        checkOutput("t2_spawn_pulse", 32'(spawn), 32'd0);
        for (int k = 0; k < 7; k++) begin
            tickOnce();
        end
        checkOutput("t2_cooling_7ticks", 32'(cooling), 32'b1000);
        tickOnce();
        checkOutput("t2_cooling_8ticks", 32'(cooling), 32'b0000);

        // Insufficient funds: item 2 level 1, nack in the first WAIT cycle
        applyStimulus(1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("t3_cost", 32'(unit_cost), 32'd120);
        applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("t3_deny", 32'(deny), 32'd1);
        checkOutput("t3_spawn", 32'(spawn), 32'd0);
        checkOutput("t3_timeout", 32'(timeout), 32'd0);
        checkOutput("t3_purchase", 32'(purchase), 32'd0);
        checkOutput("t3_cooling", 32'(cooling), 32'b0000);
        // Immediate rebuy in the deny cycle is accepted, then left to time out
        applyStimulus(1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
        stepClock();
        idleInputs();
        checkOutput("t3_rebuy_purchase", 32'(purchase), 32'd1);
        checkOutput("t3_rebuy_cost", 32'(unit_cost), 32'd60);
        checkOutput("t3_rebuy_deny_pulse", 32'(deny), 32'd0);
        repeat (15) stepClock();
        checkOutput("to_purchase_16th", 32'(purchase), 32'd1);
        checkOutput("to_not_yet", 32'(timeout), 32'd0);
        stepClock();
        checkOutput("to_deny", 32'(deny), 32'd1);
        checkOutput("to_timeout", 32'(timeout), 32'd1);
        checkOutput("to_purchase", 32'(purchase), 32'd0);
        checkOutput("to_busy", 32'(busy), 32'd0);
        checkOutput("to_spawn", 32'(spawn), 32'd0);
        // Late ack is ignored
        applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        stepClock();
        idleInputs();
        checkOutput("late_ack_spawn", 32'(spawn), 32'd0);
        checkOutput("late_ack_deny", 32'(deny), 32'd0);
        checkOutput("late_ack_timeout", 32'(timeout), 32'd0);
        checkOutput("late_ack_cooling", 32'(cooling), 32'b0000);

        // Reset mid-WAIT with item 0 cooling
        applyStimulus(1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("t4_cost0", 32'(unit_cost), 32'd10);
        applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        stepClock();
        checkOutput("t4_spawn0", 32'(spawn), 32'd1);
        checkOutput("t4_cooling0", 32'(cooling), 32'b0001);
        applyStimulus(1'b1, 2'd1, 2'd3, 1'b0, 1'b0, 1'b0);
        stepClock();
        idleInputs();
        checkOutput("t4_cost_l3", 32'(unit_cost), 32'd200);
        checkOutput("t4_purchase", 32'(purchase), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_purchase", 32'(purchase), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_cooling", 32'(cooling), 32'b0000);
        stepClock();
        rst = 1'b0;
        // Ack in IDLE is ignored
        applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        stepClock();
        checkOutput("idle_ack_spawn", 32'(spawn), 32'd0);
        checkOutput("idle_ack_deny", 32'(deny), 32'd0);
        checkOutput("idle_ack_purchase", 32'(purchase), 32'd0);
        // First buy after reset behaves normally (item 0 no longer locked)
        applyStimulus(1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("post_rst_purchase", 32'(purchase), 32'd1);
        checkOutput("post_rst_cost", 32'(unit_cost), 32'd20);
        applyStimulus(1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
        stepClock();
        idleInputs();
        checkOutput("post_rst_spawn", 32'(spawn), 32'd1);
        checkOutput("post_rst_item", 32'(spawn_item), 32'd0);
        checkOutput("post_rst_cooling", 32'(cooling), 32'b0001);
        stepClock();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
